rotate_disp_n: RTL

Parametrised rotating-square display engine for an N-digit multiplexed seven-segment display. A single square (or, optionally, a square plus trail) travels around the display: across the upper half of every digit, then back across the lower half. The block integrates the position sequencer and the digit-scan multiplexer behind one module. It directly drives the board's active-low anode and segment pins.

---
 rtl/rotate_disp_n.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rotate_disp_n.sv
// Rotating-square engine for an NDIG-digit multiplexed seven-segment display (active-low pins).
// Optional feature: define ROTATE_TRAIL_EN to also draw the previous position as a trail.
module rotate_disp_n #(
    parameter int NDIG     = 4,
    parameter int STEP_CYC = 25_000_000,
    parameter int SCAN_CYC = 50_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clockwise,
    output logic [NDIG-1:0]           an,
    output logic [7:0]                digit,
    output logic [$clog2(2*NDIG)-1:0] pos
);

    localparam int PW = $clog2(2*NDIG);
    localparam int TW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam int SW = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
    localparam int IW = $clog2(NDIG);

    localparam logic [PW-1:0] POS_LAST  = PW'(2*NDIG-1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(STEP_CYC-1);
    localparam logic [SW-1:0] SCNT_LAST = SW'(SCAN_CYC-1);
    localparam logic [IW-1:0] SIDX_LAST = IW'(NDIG-1);

    localparam logic [7:0] SEG_UPPER = 8'b1001_1100;
    localparam logic [7:0] SEG_LOWER = 8'b1010_0011;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Pattern that position p paints on digit d: upper squares run left to right, lower ones back.
    function automatic logic [7:0] square_seg(input logic [PW-1:0] p, input logic [IW-1:0] d);
        logic [7:0] seg;
        seg = SEG_BLANK;
        if (int'(p) < NDIG) begin
            if (int'(d) == NDIG - 1 - int'(p)) seg = SEG_UPPER;
            else                               seg = SEG_BLANK;
        end else begin
            if (int'(d) == int'(p) - NDIG) seg = SEG_LOWER;
            else                           seg = SEG_BLANK;
        end
        return seg;
    endfunction

    logic [TW-1:0]   r_tcnt;
    logic [PW-1:0]   r_pos;
    logic [SW-1:0]   r_scnt;
    logic [IW-1:0]   r_sidx;
    logic [NDIG-1:0] r_an;
    logic [7:0]      r_digit;

    logic            w_step;
    logic [TW-1:0]   w_tcnt_nxt;
    logic [PW-1:0]   w_pos_nxt;
    logic [SW-1:0]   w_scnt_nxt;
    logic [IW-1:0]   w_sidx_nxt;
    logic [NDIG-1:0] w_an_nxt;
    logic [7:0]      w_digit_nxt;

`ifdef ROTATE_TRAIL_EN
    logic [PW-1:0]   r_trail;
    logic [PW-1:0]   w_trail_nxt;
`endif

    // Step timer and position sequencer; direction is only looked at on the step cycle.
    always_comb begin
        w_step     = enable && (r_tcnt == TCNT_LAST);
        w_tcnt_nxt = r_tcnt;
        w_pos_nxt  = r_pos;
        if (!enable) begin
            w_tcnt_nxt = '0;
        end else if (w_step) begin
            w_tcnt_nxt = '0;
        end else begin
            w_tcnt_nxt = r_tcnt + TW'(1);
        end
        if (w_step) begin
            if (clockwise) w_pos_nxt = (r_pos == POS_LAST) ? '0 : r_pos + PW'(1);
            else           w_pos_nxt = (r_pos == '0) ? POS_LAST : r_pos - PW'(1);
        end else begin
            w_pos_nxt = r_pos;
        end
    end

    // Free-running scan prescaler and digit index, plus next anode/segment values.
    always_comb begin
        w_scnt_nxt = r_scnt;
        w_sidx_nxt = r_sidx;
        w_an_nxt   = '1;
        if (r_scnt == SCNT_LAST) begin
            w_scnt_nxt = '0;
            w_sidx_nxt = (r_sidx == SIDX_LAST) ? '0 : r_sidx + IW'(1);
        end else begin
            w_scnt_nxt = r_scnt + SW'(1);
            w_sidx_nxt = r_sidx;
        end
        for (int i = 0; i < NDIG; i++) begin
            w_an_nxt[i] = (IW'(i) != r_sidx);
        end
`ifdef ROTATE_TRAIL_EN
        w_digit_nxt = square_seg(r_pos, r_sidx) & square_seg(r_trail, r_sidx);
`else
        w_digit_nxt = square_seg(r_pos, r_sidx);
`endif
    end

`ifdef ROTATE_TRAIL_EN
    // Trail follows the old position on a step and collapses onto pos while frozen.
    always_comb begin
        w_trail_nxt = r_trail;
        if (w_step || !enable) w_trail_nxt = r_pos;
        else                   w_trail_nxt = r_trail;
    end

    // Trail register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_trail <= '0;
        else        r_trail <= w_trail_nxt;
    end
`endif

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tcnt  <= '0;
            r_pos   <= '0;
            r_scnt  <= '0;
            r_sidx  <= '0;
            r_an    <= '1;
            r_digit <= SEG_BLANK;
        end else begin
            r_tcnt  <= w_tcnt_nxt;
            r_pos   <= w_pos_nxt;
            r_scnt  <= w_scnt_nxt;
            r_sidx  <= w_sidx_nxt;
            r_an    <= w_an_nxt;
            r_digit <= w_digit_nxt;
        end
    end

    assign an    = r_an;
    assign digit = r_digit;
    assign pos   = r_pos;

endmodule
